// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
//
// Writeback stage of the CPU datapath: drives the register file write port.
// One retiring instruction is accepted per handshake. Non-load instructions
// commit their result in the cycle after accept. Loads wait for the data-memory
// response, extract the addressed byte/half/word, and then commit. A load that
// never gets a response is abandoned after TIMEOUT cycles with a fault pulse.
//
// Parameters:
//   TIMEOUT      max cycles spent in WAIT_MEM before a load is abandoned (1..255)
//
// Optional feature macro:
//   WB_MISALIGN_CHECK_EN  when defined, misaligned LH/LHU/LW fault at accept
//                         instead of issuing a memory wait.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   inValid      in   retiring instruction presented
//   inReady      out  unit can accept (state == IDLE)
//   inst         in   instruction word (opcode [6:0], rd [11:7], funct3 [14:12])
//   aluResult    in   ALU result / load byte address
//   pc           in   PC of the instruction
//   imm32        in   sign-extended immediate
//   memRspValid  in   load data valid (one-cycle pulse)
//   memRdata     in   aligned word containing the load address
//   regWrite     out  register-file write enable (one-cycle pulse, registered)
//   rd           out  destination register (registered, holds when no write)
//   writeData    out  write value (registered, holds when no write)
//   busy         out  high while waiting for memory
//   fault        out  one-cycle pulse: illegal funct3, timeout, misalignment
//   dbgState     out  current FSM state, for observation only
//
// Handshake: an instruction is taken on a rising edge where inValid && inReady.
// The producer must hold inst/aluResult/pc/imm32 stable while inValid is high
// and inReady is low; nothing is consumed on any other edge.
// -----------------------------------------------------------------------------
module writeback_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inValid,
    output logic        inReady,
    input  logic [31:0] inst,
    input  logic [31:0] aluResult,
    input  logic [31:0] pc,
    input  logic [31:0] imm32,
    input  logic        memRspValid,
    input  logic [31:0] memRdata,
    output logic        regWrite,
    output logic [4:0]  rd,
    output logic [31:0] writeData,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  dbgState
);

    // Opcodes
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_J     = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Counter value seen on the TIMEOUT-th WAIT_MEM edge.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_MEM = 2'b01
    } state_t;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        regwrite_q;
    logic [4:0]  rd_q;
    logic [31:0] wdata_q;
    logic        fault_q;

    // Fields of the accepted load, kept for the response cycle.
    logic [4:0]  ld_rd_q;
    logic [2:0]  ld_f3_q;
    logic [1:0]  ld_off_q;

    // Decode of the presented instruction
    logic [6:0]  in_op;
    logic [4:0]  in_rd;
    logic [2:0]  in_f3;
    logic [1:0]  in_off;
    logic        is_load;
    logic        ld_illegal;
    logic        ld_misalign;

    assign in_op  = inst[6:0];
    assign in_rd  = inst[11:7];
    assign in_f3  = inst[14:12];
    assign in_off = aluResult[1:0];
    assign is_load = (in_op == OP_L);

    assign ld_illegal = (in_f3 == 3'b011) || (in_f3 == 3'b110) || (in_f3 == 3'b111);

`ifdef WB_MISALIGN_CHECK_EN
    assign ld_misalign = (((in_f3 == F3_LH) || (in_f3 == F3_LHU)) && in_off[0])
                       || ((in_f3 == F3_LW) && (in_off != 2'b00));
`else
    assign ld_misalign = 1'b0;
`endif

    // Upper instruction bits are not needed by this stage.
    logic unused_inst_bits;
    assign unused_inst_bits = ^inst[31:15];

    // Non-load commit value, selected by opcode.
    logic        nl_write_d;
    logic [31:0] nl_data_d;

    always_comb begin
        nl_write_d = 1'b0;
        nl_data_d  = 32'd0;
        case (in_op)
            OP_R, OP_I: begin
                nl_write_d = 1'b1;
                nl_data_d  = aluResult;
            end
            OP_J, OP_JALR: begin
                nl_write_d = 1'b1;
                nl_data_d  = pc + 32'd4;
            end
            OP_LUI: begin
                nl_write_d = 1'b1;
                nl_data_d  = imm32;
            end
            OP_AUIPC: begin
                nl_write_d = 1'b1;
                nl_data_d  = pc + imm32;
            end
            default: begin
                nl_write_d = 1'b0;
                nl_data_d  = 32'd0;
            end
        endcase
    end

    // Load data extraction from the response word. Halfword selection uses only
    // offset bit 1, so an unchecked odd halfword address reads its containing
    // aligned half; LW always returns the full word.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data_d;

    always_comb begin
        ld_byte = memRdata[7:0];
        case (ld_off_q)
            2'd0:    ld_byte = memRdata[7:0];
            2'd1:    ld_byte = memRdata[15:8];
            2'd2:    ld_byte = memRdata[23:16];
            default: ld_byte = memRdata[31:24];
        endcase

        ld_half = ld_off_q[1] ? memRdata[31:16] : memRdata[15:0];

        case (ld_f3_q)
            F3_LB:   ld_data_d = {{24{ld_byte[7]}}, ld_byte};
            F3_LBU:  ld_data_d = {24'd0, ld_byte};
            F3_LH:   ld_data_d = {{16{ld_half[15]}}, ld_half};
            F3_LHU:  ld_data_d = {16'd0, ld_half};
            default: ld_data_d = memRdata;
        endcase
    end

    // Main FSM. regWrite and fault default low each cycle so they are
    // single-cycle pulses; rd/writeData only change on an actual write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            regwrite_q <= 1'b0;
            rd_q       <= 5'd0;
            wdata_q    <= 32'd0;
            fault_q    <= 1'b0;
            ld_rd_q    <= 5'd0;
            ld_f3_q    <= 3'd0;
            ld_off_q   <= 2'd0;
        end else begin
            regwrite_q <= 1'b0;
            fault_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    // memRspValid is ignored here: no load is outstanding.
                    if (inValid) begin
                        if (is_load) begin
                            if (ld_illegal || ld_misalign) begin
                                fault_q <= 1'b1;
                            end else begin
                                state_q  <= WAIT_MEM;
                                cnt_q    <= 8'd0;
                                ld_rd_q  <= in_rd;
                                ld_f3_q  <= in_f3;
                                ld_off_q <= in_off;
                            end
                        end else if (nl_write_d && (in_rd != 5'd0)) begin
                            regwrite_q <= 1'b1;
                            rd_q       <= in_rd;
                            wdata_q    <= nl_data_d;
                        end
                    end
                end
                WAIT_MEM: begin
                    // A response on the timeout edge takes priority.
                    if (memRspValid) begin
                        state_q <= IDLE;
                        if (ld_rd_q != 5'd0) begin
                            regwrite_q <= 1'b1;
                            rd_q       <= ld_rd_q;
                            wdata_q    <= ld_data_d;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        state_q <= IDLE;
                        fault_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign inReady   = (state_q == IDLE);
    assign busy      = (state_q == WAIT_MEM);
    assign regWrite  = regwrite_q;
    assign rd        = rd_q;
    assign writeData = wdata_q;
    assign fault     = fault_q;
    assign dbgState  = state_q;

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

  localparam int unsigned TIMEOUT = 4;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_J     = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inValid = 1'b0;
  logic [31:0] inst = '0;
  logic [31:0] aluResult = '0;
  logic [31:0] pc = '0;
  logic [31:0] imm32 = '0;
  logic        memRspValid = 1'b0;
  logic [31:0] memRdata = '0;
  logic        inReady;
  logic        regWrite;
  logic [4:0]  rd;
  logic [31:0] writeData;
  logic        busy;
  logic        fault;
  logic [1:0]  dbgState;

  always #5 clk = ~clk;

  writeback_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .inst(inst),
    .aluResult(aluResult), .pc(pc), .imm32(imm32), .memRspValid(memRspValid),
    .memRdata(memRdata), .regWrite(regWrite), .rd(rd), .writeData(writeData),
    .busy(busy), .fault(fault), .dbgState(dbgState)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;
  logic [36:0] exp_q[$];        // {rd, writeData} of expected writes
  logic [4:0]  last_rd = '0;    // model of the held rd/writeData outputs
  logic [31:0] last_wd = '0;

  function automatic logic [31:0] mk_inst(input logic [6:0] op, input logic [4:0] r, input logic [2:0] f3);
    return {$urandom_range(0, 131071), f3, r, op};
  endfunction

  // Expected load result, built with shifts of the response word.
  function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] sb;
    logic [31:0] sh;
    sb = w >> (8 * a);
    sh = a[1] ? (w >> 16) : w;
    case (f3)
      3'b000:  return {{24{sb[7]}}, sb[7:0]};
      3'b100:  return {24'd0, sb[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic accept(input logic [31:0] i, input logic [31:0] a, input logic [31:0] p, input logic [31:0] im);
    @(negedge clk);
    inValid = 1'b1; inst = i; aluResult = a; pc = p; imm32 = im;
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  task automatic idle_cycle(input logic rsp, input logic [31:0] data);
    @(negedge clk);
    memRspValid = rsp; memRdata = data;
    @(posedge clk);
    #1;
    memRspValid = 1'b0;
  endtask

  task automatic push_write(input logic [4:0] r, input logic [31:0] v);
    exp_q.push_back({r, v});
  endtask

  // Load scenario: accept, observe 'waits' busy cycles, respond, check commit.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [4:0] r,
                         input logic [31:0] addr, input logic [31:0] data, input int waits);
    logic        exp_we;
    logic [36:0] e;
    exp_we = (r != 5'd0);
    if (exp_we) push_write(r, ld_model(f3, addr[1:0], data));
    accept(mk_inst(OP_L, r, f3), addr, $urandom, $urandom);
    for (int k = 0; k < waits; k++) begin
      n_checks++;
      if (busy !== 1'b1 || inReady !== 1'b0 || regWrite !== 1'b0 || fault !== 1'b0)
        $display("FAIL %s_wait%0d: busy=%b inReady=%b regWrite=%b fault=%b, want 1 0 0 0", tag, k, busy, inReady, regWrite, fault);
      else n_pass++;
      if (k < waits - 1) idle_cycle(1'b0, $urandom);
    end
    idle_cycle(1'b1, data);
    n_checks++;
    if (regWrite !== exp_we || fault !== 1'b0 || inReady !== 1'b1 || busy !== 1'b0)
      $display("FAIL %s_commit: regWrite=%b fault=%b inReady=%b busy=%b, want %b 0 1 0", tag, regWrite, fault, inReady, busy, exp_we);
    else n_pass++;
    n_checks++;
    if (exp_we) begin
      e = exp_q.pop_front();
      if ({rd, writeData} !== e) $display("FAIL %s_data: rd=%0d data=%h, want rd=%0d data=%h", tag, rd, writeData, e[36:32], e[31:0]);
      else n_pass++;
      last_rd = e[36:32]; last_wd = e[31:0];
    end else begin
      if ({rd, writeData} !== {last_rd, last_wd}) $display("FAIL %s_hold: rd=%0d data=%h, want rd=%0d data=%h", tag, rd, writeData, last_rd, last_wd);
      else n_pass++;
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b0;
    #12;
    n_checks++;
    if (inReady !== 1'b1 || busy !== 1'b0) $display("FAIL reset_ready: inReady=%b busy=%b, want 1 0", inReady, busy);
    else n_pass++;
    n_checks++;
    if (regWrite !== 1'b0 || fault !== 1'b0) $display("FAIL reset_pulses: regWrite=%b fault=%b, want 0 0", regWrite, fault);
    else n_pass++;
    n_checks++;
    if (rd !== 5'd0 || writeData !== 32'd0) $display("FAIL reset_data: rd=%0d data=%h, want 0 0", rd, writeData);
    else n_pass++;
    n_checks++;
    if (dbgState !== 2'd0) $display("FAIL reset_state: dbgState=%0d, want 0", dbgState);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    last_rd = '0; last_wd = '0;
  endtask

  task automatic test_rtype();
    logic [36:0] e;
    push_write(5'd5, 32'h0000_1234);
    accept(mk_inst(OP_R, 5'd5, 3'd0), 32'h0000_1234, $urandom, $urandom);
    n_checks++;
    if (regWrite !== 1'b1) $display("FAIL rtype_we: regWrite=%b, want 1", regWrite);
    else n_pass++;
    e = exp_q.pop_front();
    last_rd = e[36:32]; last_wd = e[31:0];
    n_checks++;
    if ({rd, writeData} !== e) $display("FAIL rtype_data: rd=%0d data=%h, want rd=%0d data=%h", rd, writeData, e[36:32], e[31:0]);
    else n_pass++;
    idle_cycle(1'b0, 32'd0);
    n_checks++;
    if (regWrite !== 1'b0 || rd !== 5'd5 || writeData !== 32'h0000_1234)
      $display("FAIL rtype_one_cycle: regWrite=%b rd=%0d data=%h, want 0 5 00001234", regWrite, rd, writeData);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [36:0] e;
    push_write(5'd1, 32'h0000_0104);
    push_write(5'd2, 32'h0000_1100);
    accept(mk_inst(OP_J, 5'd1, 3'd0), $urandom, 32'h0000_0100, $urandom);
    e = exp_q.pop_front();
    n_checks++;
    if (regWrite !== 1'b1 || {rd, writeData} !== e || inReady !== 1'b1)
      $display("FAIL b2b_jal: regWrite=%b rd=%0d data=%h inReady=%b, want 1 %0d %h 1", regWrite, rd, writeData, inReady, e[36:32], e[31:0]);
    else n_pass++;
    accept(mk_inst(OP_AUIPC, 5'd2, 3'd0), $urandom, 32'h0000_0100, 32'h0000_1000);
    e = exp_q.pop_front();
    n_checks++;
    if (regWrite !== 1'b1 || {rd, writeData} !== e)
      $display("FAIL b2b_auipc: regWrite=%b rd=%0d data=%h, want 1 %0d %h", regWrite, rd, writeData, e[36:32], e[31:0]);
    else n_pass++;
    last_rd = 5'd2; last_wd = 32'h0000_1100;
    accept(mk_inst(OP_I, 5'd0, 3'd0), 32'hDEAD_BEEF, $urandom, $urandom);
    n_checks++;
    if (regWrite !== 1'b0 || rd !== last_rd || writeData !== last_wd)
      $display("FAIL b2b_rd0: regWrite=%b rd=%0d data=%h, want 0 %0d %h", regWrite, rd, writeData, last_rd, last_wd);
    else n_pass++;
  endtask

  task automatic test_random_nonload();
    logic [6:0]  ops[11];
    logic [6:0]  op;
    logic [4:0]  r;
    logic [31:0] a, p, im, v;
    logic        has, exp_we;
    logic [36:0] e;
    ops = '{OP_R, OP_I, OP_J, OP_JALR, OP_LUI, OP_AUIPC, OP_S, OP_B, OP_SYS, 7'b0001111, 7'b1111111};
    for (int i = 0; i < 20; i++) begin
      op = ops[$urandom_range(0, 10)];
      r  = 5'($urandom_range(0, 31));
      a = $urandom; p = $urandom; im = $urandom;
      has = 1'b1;
      v = 32'd0;
      case (op)
        OP_R, OP_I:     v = a;
        OP_J, OP_JALR:  v = p + 32'd4;
        OP_LUI:         v = im;
        OP_AUIPC:       v = p + im;
        default:        has = 1'b0;
      endcase
      exp_we = has && (r != 5'd0);
      if (exp_we) push_write(r, v);
      accept(mk_inst(op, r, 3'($urandom_range(0, 7))), a, p, im);
      n_checks++;
      if (regWrite !== exp_we || fault !== 1'b0)
        $display("FAIL rand%0d_we: op=%b rd=%0d regWrite=%b fault=%b, want %b 0", i, op, r, regWrite, fault, exp_we);
      else n_pass++;
      n_checks++;
      if (exp_we) begin
        e = exp_q.pop_front();
        if ({rd, writeData} !== e) $display("FAIL rand%0d_data: rd=%0d data=%h, want rd=%0d data=%h", i, rd, writeData, e[36:32], e[31:0]);
        else n_pass++;
        last_rd = e[36:32]; last_wd = e[31:0];
      end else begin
        if ({rd, writeData} !== {last_rd, last_wd}) $display("FAIL rand%0d_hold: rd=%0d data=%h, want rd=%0d data=%h", i, rd, writeData, last_rd, last_wd);
        else n_pass++;
      end
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s[5];
    logic [2:0]  f3;
    logic [31:0] addr;
    f3s = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    do_load("lb", 3'b000, 5'd3, 32'h0000_2001, 32'h0000_8000, 3);
    do_load("lbu", 3'b100, 5'd3, 32'h0000_2001, 32'h0000_8000, 3);
    do_load("lh_hi", 3'b001, 5'd4, 32'h0000_2002, 32'h8765_4321, 1);
    do_load("lhu_hi", 3'b101, 5'd4, 32'h0000_2002, 32'h8765_4321, 2);
    for (int i = 0; i < 10; i++) begin
      f3 = f3s[$urandom_range(0, 4)];
      addr = $urandom;
      if (f3 == 3'b001 || f3 == 3'b101) addr[0] = 1'b0;
      if (f3 == 3'b010) addr[1:0] = 2'b00;
      do_load("ld_rand", f3, 5'($urandom_range(0, 31)), addr, $urandom, $urandom_range(1, TIMEOUT));
    end
  endtask

  task automatic test_illegal_load();
    logic [2:0] bad[3];
    bad = '{3'b011, 3'b110, 3'b111};
    for (int i = 0; i < 3; i++) begin
      accept(mk_inst(OP_L, 5'd6, bad[i]), 32'h0000_4000, $urandom, $urandom);
      n_checks++;
      if (fault !== 1'b1 || regWrite !== 1'b0 || inReady !== 1'b1 || busy !== 1'b0)
        $display("FAIL illegal_f3_%b: fault=%b regWrite=%b inReady=%b busy=%b, want 1 0 1 0", bad[i], fault, regWrite, inReady, busy);
      else n_pass++;
    end
    idle_cycle(1'b0, 32'd0);
    n_checks++;
    if (fault !== 1'b0) $display("FAIL illegal_pulse: fault=%b, want 0", fault);
    else n_pass++;
  endtask

  task automatic test_timeout();
    accept(mk_inst(OP_L, 5'd7, 3'b010), 32'h0000_5000, $urandom, $urandom);
    for (int k = 0; k < TIMEOUT; k++) begin
      n_checks++;
      if (busy !== 1'b1 || fault !== 1'b0) $display("FAIL timeout_wait%0d: busy=%b fault=%b, want 1 0", k, busy, fault);
      else n_pass++;
      if (k < TIMEOUT - 1) idle_cycle(1'b0, 32'd0);
    end
    idle_cycle(1'b0, 32'd0);
    n_checks++;
    if (fault !== 1'b1 || regWrite !== 1'b0 || inReady !== 1'b1 || busy !== 1'b0)
      $display("FAIL timeout_fault: fault=%b regWrite=%b inReady=%b busy=%b, want 1 0 1 0", fault, regWrite, inReady, busy);
    else n_pass++;
    // Late response arrives while IDLE and must be ignored.
    idle_cycle(1'b1, 32'hCAFE_F00D);
    n_checks++;
    if (fault !== 1'b0 || regWrite !== 1'b0 || rd !== last_rd || writeData !== last_wd)
      $display("FAIL idle_rsp_ignored: fault=%b regWrite=%b rd=%0d data=%h, want 0 0 %0d %h", fault, regWrite, rd, writeData, last_rd, last_wd);
    else n_pass++;
    // Response on the timeout edge wins.
    do_load("rsp_on_timeout", 3'b010, 5'd8, 32'h0000_6000, 32'h1357_9BDF, TIMEOUT);
  endtask

  task automatic test_misalign();
`ifdef WB_MISALIGN_CHECK_EN
    accept(mk_inst(OP_L, 5'd9, 3'b010), 32'h0000_3002, $urandom, $urandom);
    n_checks++;
    if (fault !== 1'b1 || regWrite !== 1'b0 || inReady !== 1'b1 || busy !== 1'b0)
      $display("FAIL misalign_lw: fault=%b regWrite=%b inReady=%b busy=%b, want 1 0 1 0", fault, regWrite, inReady, busy);
    else n_pass++;
    accept(mk_inst(OP_L, 5'd9, 3'b001), 32'h0000_3001, $urandom, $urandom);
    n_checks++;
    if (fault !== 1'b1 || busy !== 1'b0)
      $display("FAIL misalign_lh: fault=%b busy=%b, want 1 0", fault, busy);
    else n_pass++;
`else
    do_load("lw_unaligned", 3'b010, 5'd9, 32'h0000_3002, 32'hA5B6_C7D8, 1);
    do_load("lh_odd", 3'b001, 5'd10, 32'h0000_3003, 32'hF00F_1234, 2);
`endif
  endtask

  task automatic test_reset_mid_wait();
    accept(mk_inst(OP_L, 5'd4, 3'b000), 32'h0000_7000, $urandom, $urandom);
    idle_cycle(1'b0, 32'd0);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL rstwait_busy: busy=%b, want 1", busy);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || inReady !== 1'b1 || regWrite !== 1'b0 || fault !== 1'b0 || rd !== 5'd0 || writeData !== 32'd0)
      $display("FAIL rstwait_async: busy=%b inReady=%b regWrite=%b fault=%b rd=%0d data=%h, want 0 1 0 0 0 0", busy, inReady, regWrite, fault, rd, writeData);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    last_rd = '0; last_wd = '0;
    idle_cycle(1'b1, 32'h1111_2222);
    n_checks++;
    if (regWrite !== 1'b0 || rd !== 5'd0 || writeData !== 32'd0 || busy !== 1'b0)
      $display("FAIL rstwait_rsp_ignored: regWrite=%b rd=%0d data=%h busy=%b, want 0 0 0 0", regWrite, rd, writeData, busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_back_to_back();
    test_random_nonload();
    test_loads();
    test_illegal_load();
    test_timeout();
    test_misalign();
    test_reset_mid_wait();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d expected writes never seen", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
